// File: rtl/mon_frame_fifo_rx_pkg.sv
// Shared types and default sizes for the NeXT ASIC monitor-link receive path.
package nextasic_pkg;

  localparam int MON_FRAME_WIDTH = 40;
  localparam int MON_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mon_frame_fifo_rx_if.sv
// Valid/ready frame handshake between the monitor receiver and its consumer.
interface mon_frame_if #(
  parameter int WIDTH = nextasic_pkg::MON_FRAME_WIDTH
);

  logic [WIDTH-1:0] frame_data;
  logic             frame_valid;
  logic             frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/mon_frame_fifo_rx_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on dout whenever non-empty.
module mon_sync_fifo import nextasic_pkg::*; #(
  parameter int WIDTH = MON_FRAME_WIDTH,
  parameter int DEPTH = MON_FIFO_DEPTH
) (
  input  logic                     mon_clk,
  input  logic                     mon_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge mon_clk or negedge mon_rst_n) begin
    if (!mon_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge mon_clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mon_frame_fifo_rx.sv
// Monitor-link frame receiver: deserialises to_mon, checks the stop bit, buffers good frames.
//   state   | meaning
//   RX_IDLE | line idle, waiting for a start bit
//   RX_DATA | shifting in WIDTH payload bits, MSB first
//   RX_STOP | sampling stop bit; push, flag framing error or overflow
module mon_frame_fifo_rx import nextasic_pkg::*; #(
  parameter int   WIDTH      = MON_FRAME_WIDTH,
  parameter int   DEPTH      = MON_FIFO_DEPTH,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                   mon_clk,
  input  logic                   mon_rst_n,
  input  logic                   to_mon,
  mon_frame_if.master            frame_if,
  output logic                   in_frame,
  output logic                   frame_err,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic             stop_ok;
  logic             push;
  logic             err_d;
  logic             ovf_d;

  assign frame_if.frame_valid = !fifo_empty;
  assign pop     = frame_if.frame_valid && frame_if.frame_ready;
  // A pop on the stop edge frees a slot, so a full FIFO still accepts the frame.
  assign push_ok = !fifo_full || pop;
  assign stop_ok = (to_mon == IDLE_LEVEL);

  always_ff @(posedge mon_clk or negedge mon_rst_n) begin
    if (!mon_rst_n) state_q <= RX_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: if (to_mon != IDLE_LEVEL) state_d = RX_DATA;
      RX_DATA: if (bit_cnt_q == LAST_BIT) state_d = RX_STOP;
      RX_STOP: state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    in_frame = 1'b0;
    push     = 1'b0;
    err_d    = 1'b0;
    ovf_d    = 1'b0;
    case (state_q)
      RX_DATA: in_frame = 1'b1;
      RX_STOP: begin
        in_frame = 1'b1;
        push     = stop_ok && push_ok;
        err_d    = !stop_ok;
        ovf_d    = stop_ok && !push_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mon_clk or negedge mon_rst_n) begin
    if (!mon_rst_n) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_err <= err_d;
      overflow  <= ovf_d;
      if (err_d || ovf_d) drop_count <= sat_inc8(drop_count);
      if (state_q == RX_IDLE) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (state_q == RX_DATA) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        shift_q   <= {shift_q[WIDTH-2:0], to_mon};
      end
    end
  end

  mon_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .mon_clk   (mon_clk),
    .mon_rst_n (mon_rst_n),
    .push      (push),
    .pop       (pop),
    .din       (shift_q),
    .dout      (frame_if.frame_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_mon_frame_fifo_rx.sv
// Bench for mon_frame_fifo_rx: default build (40/4/idle-high) and a narrow build (8/2/idle-low).
module tb_mon_frame_fifo_rx;

  localparam int WA = 40;
  localparam int DA = 4;
  localparam int WB = 8;
  localparam int DB = 2;

  logic mon_clk   = 1'b0;
  logic mon_rst_n = 1'b0;
  logic to_mon_a  = 1'b1;
  logic to_mon_b  = 1'b0;

  always #5 mon_clk = ~mon_clk;

  mon_frame_if #(.WIDTH(WA)) if_a ();
  mon_frame_if #(.WIDTH(WB)) if_b ();

  logic       in_frame_a, err_a, ovf_a;
  logic       in_frame_b, err_b, ovf_b;
  logic [7:0] drop_a, drop_b;
  logic [2:0] lvl_a;
  logic [1:0] lvl_b;

  mon_frame_fifo_rx #(.WIDTH(WA), .DEPTH(DA), .IDLE_LEVEL(1'b1)) dut_a (
    .mon_clk    (mon_clk),
    .mon_rst_n  (mon_rst_n),
    .to_mon     (to_mon_a),
    .frame_if   (if_a),
    .in_frame   (in_frame_a),
    .frame_err  (err_a),
    .overflow   (ovf_a),
    .drop_count (drop_a),
    .fifo_level (lvl_a)
  );

  mon_frame_fifo_rx #(.WIDTH(WB), .DEPTH(DB), .IDLE_LEVEL(1'b0)) dut_b (
    .mon_clk    (mon_clk),
    .mon_rst_n  (mon_rst_n),
    .to_mon     (to_mon_b),
    .frame_if   (if_b),
    .in_frame   (in_frame_b),
    .frame_err  (err_b),
    .overflow   (ovf_b),
    .drop_count (drop_b),
    .fifo_level (lvl_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [WA-1:0] exp_a[$];
  logic [WB-1:0] exp_b[$];

  typedef struct {
    logic [WA-1:0] data;
    bit            stop;
    bit            ready;
    bit            exp_err;
    bit            exp_ovf;
    int            exp_level;
    int            exp_drop;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_empty(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got empty scoreboard, expected a queued frame", name);
  endtask

  task automatic put_a(input logic b);
    to_mon_a = b;
    @(negedge mon_clk);
  endtask

  task automatic put_b(input logic b);
    to_mon_b = b;
    @(negedge mon_clk);
  endtask

  task automatic body_a(input logic [WA-1:0] d);
    put_a(1'b0);
    for (int i = WA - 1; i >= 0; i--) put_a(d[i]);
  endtask

  task automatic body_b(input logic [WB-1:0] d);
    put_b(1'b1);
    for (int i = WB - 1; i >= 0; i--) put_b(d[i]);
  endtask

  task automatic pop_a(input string name);
    check({name, "_valid"}, 64'(if_a.frame_valid), 64'd1);
    if (exp_a.size() == 0) sb_empty(name);
    else check({name, "_data"}, 64'(if_a.frame_data), 64'(exp_a.pop_front()));
    if_a.frame_ready = 1'b1;
    @(negedge mon_clk);
    if_a.frame_ready = 1'b0;
  endtask

  task automatic pop_b(input string name);
    check({name, "_valid"}, 64'(if_b.frame_valid), 64'd1);
    if (exp_b.size() == 0) sb_empty(name);
    else check({name, "_data"}, 64'(if_b.frame_data), 64'(exp_b.pop_front()));
    if_b.frame_ready = 1'b1;
    @(negedge mon_clk);
    if_b.frame_ready = 1'b0;
  endtask

  initial begin
    logic [WA-1:0] d;
    if_a.frame_ready = 1'b0;
    if_b.frame_ready = 1'b0;

    //            data     stop rdy err ovf lvl drop
    tbl[0] = '{40'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[1] = '{40'h02, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0};
    tbl[2] = '{40'h03, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0};
    tbl[3] = '{40'h04, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};
    tbl[4] = '{40'h05, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1};
    tbl[5] = '{40'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 4, 2};
    tbl[6] = '{40'h06, 1'b1, 1'b1, 1'b0, 1'b0, 4, 2};
    tbl[7] = '{40'h07, 1'b0, 1'b1, 1'b1, 1'b0, 3, 3};
    tbl[8] = '{40'h08, 1'b1, 1'b0, 1'b0, 1'b0, 4, 3};

    repeat (3) @(negedge mon_clk);
    check("rst_valid",    64'(if_a.frame_valid), 64'd0);
    check("rst_data",     64'(if_a.frame_data),  64'd0);
    check("rst_in_frame", 64'(in_frame_a),       64'd0);
    check("rst_err",      64'(err_a),            64'd0);
    check("rst_ovf",      64'(ovf_a),            64'd0);
    check("rst_drop",     64'(drop_a),           64'd0);
    check("rst_level",    64'(lvl_a),            64'd0);
    mon_rst_n = 1'b1;
    repeat (2) @(negedge mon_clk);

    // single frame, consumer not ready
    d = 40'h8000000001;
    put_a(1'b0);
    check("single_in_frame_start", 64'(in_frame_a), 64'd1);
    for (int i = WA - 1; i >= 0; i--) put_a(d[i]);
    check("single_in_frame_stop", 64'(in_frame_a), 64'd1);
    to_mon_a = 1'b1;
    exp_a.push_back(d);
    @(negedge mon_clk);
    check("single_valid",    64'(if_a.frame_valid), 64'd1);
    check("single_level",    64'(lvl_a),            64'd1);
    check("single_err",      64'(err_a),            64'd0);
    check("single_ovf",      64'(ovf_a),            64'd0);
    check("single_in_frame", 64'(in_frame_a),       64'd0);
    repeat (2) @(negedge mon_clk);
    pop_a("single_pop");
    check("single_empty", 64'(if_a.frame_valid), 64'd0);

    // back-to-back table: fill, overflow, framing errors, full-with-pop
    for (int k = 0; k < 9; k++) begin
      body_a(tbl[k].data);
      to_mon_a = tbl[k].stop;
      if_a.frame_ready = tbl[k].ready;
      if (tbl[k].ready) begin
        if (exp_a.size() == 0) sb_empty($sformatf("tbl%0d_head", k));
        else check($sformatf("tbl%0d_head", k), 64'(if_a.frame_data), 64'(exp_a.pop_front()));
      end
      if (tbl[k].stop && !tbl[k].exp_ovf) exp_a.push_back(tbl[k].data);
      @(negedge mon_clk);
      if_a.frame_ready = 1'b0;
      check($sformatf("tbl%0d_err", k),      64'(err_a),      64'(tbl[k].exp_err));
      check($sformatf("tbl%0d_ovf", k),      64'(ovf_a),      64'(tbl[k].exp_ovf));
      check($sformatf("tbl%0d_level", k),    64'(lvl_a),      64'(tbl[k].exp_level));
      check($sformatf("tbl%0d_drop", k),     64'(drop_a),     64'(tbl[k].exp_drop));
      check($sformatf("tbl%0d_in_frame", k), 64'(in_frame_a), 64'd0);
    end
    to_mon_a = 1'b1;
    @(negedge mon_clk);
    for (int k = 0; k < 4; k++) pop_a($sformatf("drain%0d", k));
    check("drain_valid", 64'(if_a.frame_valid), 64'd0);
    check("drain_level", 64'(lvl_a),            64'd0);

    // framing error then idle: the bad stop bit must not start a new frame
    body_a(40'hAA);
    to_mon_a = 1'b0;
    @(negedge mon_clk);
    check("ferr_pulse", 64'(err_a), 64'd1);
    check("ferr_level", 64'(lvl_a), 64'd0);
    to_mon_a = 1'b1;
    @(negedge mon_clk);
    check("ferr_pulse_end", 64'(err_a),      64'd0);
    check("ferr_no_resync", 64'(in_frame_a), 64'd0);
    check("ferr_drop",      64'(drop_a),     64'd4);
    d = 40'h55AA55AA55;
    body_a(d);
    to_mon_a = 1'b1;
    exp_a.push_back(d);
    @(negedge mon_clk);
    check("after_err_level", 64'(lvl_a), 64'd1);
    pop_a("after_err_pop");

    // reset mid-frame with a frame already buffered
    body_a(40'h0F0F0F0F0F);
    to_mon_a = 1'b1;
    @(negedge mon_clk);
    check("pre_rst_level", 64'(lvl_a), 64'd1);
    d = 40'hFEDCBA9876;
    put_a(1'b0);
    for (int i = WA - 1; i >= WA - 20; i--) put_a(d[i]);
    mon_rst_n = 1'b0;
    @(negedge mon_clk);
    check("mid_rst_in_frame", 64'(in_frame_a),       64'd0);
    check("mid_rst_valid",    64'(if_a.frame_valid), 64'd0);
    check("mid_rst_data",     64'(if_a.frame_data),  64'd0);
    check("mid_rst_level",    64'(lvl_a),            64'd0);
    check("mid_rst_drop",     64'(drop_a),           64'd0);
    to_mon_a  = 1'b1;
    mon_rst_n = 1'b1;
    repeat (3) @(negedge mon_clk);
    check("post_rst_err",      64'(err_a),      64'd0);
    check("post_rst_ovf",      64'(ovf_a),      64'd0);
    check("post_rst_in_frame", 64'(in_frame_a), 64'd0);
    d = 40'h123456789A;
    body_a(d);
    to_mon_a = 1'b1;
    exp_a.push_back(d);
    @(negedge mon_clk);
    check("post_rst_level", 64'(lvl_a), 64'd1);
    pop_a("post_rst_pop");

    // narrow build, idle-low line
    body_b(8'h5A);
    to_mon_b = 1'b0;
    exp_b.push_back(8'h5A);
    @(negedge mon_clk);
    check("b_level", 64'(lvl_b), 64'd1);
    check("b_err",   64'(err_b), 64'd0);
    pop_b("b_pop");
    check("b_empty", 64'(if_b.frame_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      body_b(8'(8'h11 * (k + 1)));
      to_mon_b = 1'b0;
      if (k < 2) exp_b.push_back(8'(8'h11 * (k + 1)));
      @(negedge mon_clk);
      check($sformatf("b_fill%0d_ovf", k),   64'(ovf_b), 64'(k == 2));
      check($sformatf("b_fill%0d_level", k), 64'(lvl_b), 64'((k < 2) ? k + 1 : 2));
    end
    check("b_ovf_drop", 64'(drop_b), 64'd1);
    for (int k = 0; k < 300; k++) begin
      body_b(8'(k));
      to_mon_b = 1'b1;
      @(negedge mon_clk);
      if (k == 0)   check("b_err_pulse", 64'(err_b),  64'd1);
      if (k == 252) check("b_drop_254",  64'(drop_b), 64'd254);
    end
    to_mon_b = 1'b0;
    @(negedge mon_clk);
    check("b_drop_sat",  64'(drop_b), 64'd255);
    check("b_sat_level", 64'(lvl_b),  64'd2);
    pop_b("b_drain0");
    pop_b("b_drain1");
    check("b_drain_empty", 64'(if_b.frame_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
